truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Self-test sequencer for a small N-input combinational function block (default 3 inputs, 1 output).
- On start, drives every input vector 0..2^N_IN-1 in order and waits a programmable settle time per vector.
- Samples the block output into a truth-table register, then compares it against an expected table and reports pass/fail.
- Sits between the board's start button/LED logic and the function under test, so exhaustive checking runs on hardware instead of only in simulation.

Parameters:
- N_IN, 3, number of function inputs; table width W = 2^N_IN.
- SETTLE, 2, cycles each vector is held before sampling; legal range >=1.
- EXPECTED, 8'b0011_0001, golden truth table, W bits wide; bit i = expected output for input vector i (MSB of vector = first input).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled; begins a sweep when sampled high in IDLE.
- abort  in  1  ends a sweep in progress; returns to IDLE without done.
- dut_y  in  1  output of the function under test.
- dut_in  out  N_IN  input vector driven to the function under test.
- busy  out  1  high while a sweep is in progress (DRIVE or SAMPLE).
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  result of the last completed sweep: 1 when table_out == EXPECTED.
- table_out  out  W  captured truth table.
- fail_mask  out  W  table_out XOR EXPECTED, updated together with pass.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state, including mid-sweep):
  - state=IDLE; dut_in=0, busy=0, done=0, pass=0, table_out=0, fail_mask=0.
  - Internal vector index and settle counter are cleared.
- States: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE:
  - dut_in=0, busy=0.
  - start=1 at a rising edge → index=0, settle count=0, table_out cleared to 0, next state DRIVE.
  - pass and fail_mask keep their previous values until FINISH.
- DRIVE:
  - dut_in=index, busy=1.
  - Settle counter increments each cycle.
  - When the counter reaches SETTLE-1 → SAMPLE. DRIVE therefore lasts exactly SETTLE cycles per vector.
- SAMPLE:
  - dut_in still = index, busy=1.
  - table_out[index] <= dut_y.
  - If index == W-1 → FINISH. Otherwise index+1, counter=0 → DRIVE.
- FINISH:
  - done=1 for exactly this cycle, busy=0, dut_in=0.
  - pass <= (final table == EXPECTED); fail_mask <= final table XOR EXPECTED.
  - The comparison uses the table including the last sample, so there is no off-by-one.
  - Next state IDLE.
- Latency:
  - The sweep occupies W*(SETTLE+1) cycles after the start edge; done is high in the following cycle.
  - With defaults: 8*3 = 24 busy cycles; done is high in cycle 25 after the edge that sampled start.
- start while busy or during FINISH: ignored; no restart, no effect on the sweep.
- start held high continuously: a new sweep begins in the cycle after FINISH (back-to-back sweeps); the table clears again.
- abort=1 in DRIVE or SAMPLE:
  - Next state IDLE, dut_in=0, busy=0, no done pulse.
  - pass and fail_mask are unchanged; table_out holds its partial contents.
  - abort has priority over SAMPLE's transition.
  - abort in IDLE or FINISH has no effect; FINISH still completes.
- abort and start both high in IDLE: abort wins, and the sweep does not start.
- Index wrap: the index never exceeds W-1; no modular wrap occurs inside a sweep.
- dut_y is assumed stable by the end of the settle window. The block does not synchronise dut_y, since the function under test is on the same clock domain.

Test Plan:
- Defaults; model a DUT whose truth table equals EXPECTED (y=1 for vectors 0, 4, 5); pulse start:
  - dut_in steps 0..7, each held 3 cycles.
  - done is high in cycle 25.
  - Response: table_out=8'h31, pass=1, fail_mask=8'h00.
- DUT output tied to 0:
  - Response: table_out=8'h00, pass=0, fail_mask=8'h31.
  - busy is high for exactly 24 cycles.
- Pulse start again at cycle 10 of a sweep:
  - No restart; done still in cycle 25; the result is identical to scenario 1.
- Assert rst asynchronously mid-cycle at sweep cycle 12:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - No done pulse follows.
  - A subsequent start produces a full, correct sweep.
- Assert abort during vector 5 after a passing sweep:
  - busy falls next cycle; no done pulse.
  - pass stays 1 and fail_mask stays 8'h00 from the previous sweep.
- SETTLE=1, start held high continuously:
  - Each vector lasts 2 cycles; done is high in cycle 17.
  - A second sweep starts in cycle 18, with table_out cleared at its start.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive self-test sequencer: sweeps every input vector through a small
// combinational block, captures its truth table and compares it to a golden one.
// Latency: W*(SETTLE+1) busy cycles after start is sampled; done pulses the cycle after.
// Backpressure: none; start is ignored while a sweep is running, abort cancels it.
//
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   start      - level-sampled in IDLE; begins a sweep
//   abort      - cancels a sweep in progress (no done pulse)
//   dut_y      - output of the function under test (same clock domain)
//   dut_in     - input vector driven to the function under test
//   busy       - high in DRIVE and SAMPLE
//   done       - one-cycle pulse in FINISH
//   pass       - last completed sweep matched EXPECTED
//   table_out  - captured truth table, bit i = response to vector i
//   fail_mask  - table_out XOR EXPECTED of the last completed sweep
module truth_table_sweeper #(
    parameter int                     N_IN     = 3,
    parameter int                     SETTLE   = 2,
    parameter logic [(2**N_IN)-1:0]   EXPECTED = 8'b0011_0001
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   dut_y,
    output logic [N_IN-1:0]        dut_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   table_out,
    output logic [(2**N_IN)-1:0]   fail_mask
);

    localparam int W  = 2**N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

    state_t          state, state_n;
    logic [N_IN-1:0] index, index_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [W-1:0]    table_n;
    logic            clr_table;
    logic            capture;
    logic            active_n;

    // Next-state logic. Outputs are registered from the next-state values so
    // that busy/dut_in/done line up with the state they describe.
    always_comb begin
        state_n   = state;
        index_n   = index;
        cnt_n     = cnt;
        clr_table = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                // abort beats start when both are high
                if (start && !abort) begin
                    state_n   = DRIVE;
                    index_n   = '0;
                    cnt_n     = '0;
                    clr_table = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (cnt == CW'(SETTLE - 1)) begin
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SAMPLE: begin
                // an abort here drops the pending sample; table keeps prior bits
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    capture = 1'b1;
                    if (index == N_IN'(W - 1)) begin
                        state_n = FINISH;
                    end else begin
                        index_n = index + 1'b1;
                        cnt_n   = '0;
                        state_n = DRIVE;
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Table including the sample taken this cycle; the verdict registered on
    // entry to FINISH therefore already sees the last vector's response.
    always_comb begin
        table_n = table_out;
        if (clr_table) begin
            table_n = '0;
        end
        if (capture) begin
            table_n[index] = dut_y;
        end
    end

    assign active_n = (state_n == DRIVE) || (state_n == SAMPLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            index     <= '0;
            cnt       <= '0;
            dut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            table_out <= '0;
            fail_mask <= '0;
        end else begin
            state     <= state_n;
            index     <= index_n;
            cnt       <= cnt_n;
            table_out <= table_n;
            busy      <= active_n;
            dut_in    <= active_n ? index_n : '0;
            done      <= (state_n == FINISH);
            // verdict becomes visible in the same cycle as the done pulse
            if (state == SAMPLE && state_n == FINISH) begin
                pass      <= (table_n == EXPECTED);
                fail_mask <= table_n ^ EXPECTED;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    localparam logic [7:0] GOLD = 8'h31;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       start1 = 1'b0;
    logic       abort1 = 1'b0;
    logic [7:0] model_tbl = 8'h31;

    logic       dut_y, dut_y1;
    logic [2:0] dut_in, dut_in1;
    logic       busy, done, pass, busy1, done1, pass1;
    logic [7:0] table_out, fail_mask, table_out1, fail_mask1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] tbl;
        logic       pass;
        logic [7:0] mask;
    } res_t;

    res_t exp_q[$];
    res_t exp_q1[$];

    always #5 clk = ~clk;

    // Behavioural function under test: response of vector v is model_tbl[v]
    assign dut_y  = model_tbl[dut_in];
    assign dut_y1 = model_tbl[dut_in1];

    truth_table_sweeper u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_y(dut_y),
        .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
        .table_out(table_out), .fail_mask(fail_mask)
    );

    truth_table_sweeper #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .dut_y(dut_y1),
        .dut_in(dut_in1), .busy(busy1), .done(done1), .pass(pass1),
        .table_out(table_out1), .fail_mask(fail_mask1)
    );

    function automatic res_t predict(input logic [7:0] f);
        res_t r;
        r.tbl  = f;
        r.pass = (f == GOLD);
        r.mask = f ^ GOLD;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dut_in, busy, done, pass, table_out, fail_mask} !== '0) begin
            errors++;
            $display("FAIL reset_state: got dut_in=%0d busy=%b done=%b pass=%b tbl=%h mask=%h, want all 0",
                     dut_in, busy, done, pass, table_out, fail_mask);
        end
        checks++;
        if ({dut_in1, busy1, done1, pass1, table_out1, fail_mask1} !== '0) begin
            errors++;
            $display("FAIL reset_state_s1: got busy=%b done=%b tbl=%h, want all 0", busy1, done1, table_out1);
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // One sweep on the SETTLE=2 instance; optional extra start pulse mid-sweep
    task automatic full_sweep(input string name, input logic [7:0] f, input int restart_at);
        int   done_cyc;
        int   done_cnt;
        int   busy_cnt;
        res_t r;
        model_tbl = f;
        exp_q.push_back(predict(f));
        start = 1'b1;
        step();
        start = 1'b0;
        done_cyc = 0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            if (busy) busy_cnt++;
            if (c <= 24) begin
                checks++;
                if (dut_in !== 3'((c - 1) / 3)) begin
                    errors++;
                    $display("FAIL %s dut_in cyc %0d: got %0d want %0d", name, c, dut_in, (c - 1) / 3);
                end
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected done at cyc %0d", name, c);
                end else begin
                    r = exp_q.pop_front();
                    if (table_out !== r.tbl || pass !== r.pass || fail_mask !== r.mask) begin
                        errors++;
                        $display("FAIL %s result: got tbl=%h pass=%b mask=%h want tbl=%h pass=%b mask=%h",
                                 name, table_out, pass, fail_mask, r.tbl, r.pass, r.mask);
                    end
                end
            end
            start = (c == restart_at);
            step();
        end
        start = 1'b0;
        checks++;
        if (done_cyc != 25 || done_cnt != 1) begin
            errors++;
            $display("FAIL %s done timing: got cyc %0d count %0d want cyc 25 count 1", name, done_cyc, done_cnt);
        end
        checks++;
        if (busy_cnt != 24) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d want 24", name, busy_cnt);
        end
    endtask

    task automatic test_golden();
        full_sweep("golden", GOLD, 0);
    endtask

    task automatic test_stuck_zero();
        full_sweep("stuck0", 8'h00, 0);
    endtask

    task automatic test_start_while_busy();
        full_sweep("restart", GOLD, 10);
    endtask

    task automatic test_async_reset();
        int done_cnt;
        model_tbl = GOLD;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 12; c++) step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dut_in, busy, done, pass, table_out, fail_mask} !== '0) begin
            errors++;
            $display("FAIL async_reset: got dut_in=%0d busy=%b pass=%b tbl=%h mask=%h, want all 0",
                     dut_in, busy, pass, table_out, fail_mask);
        end
        step();
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (done || busy) done_cnt++;
            step();
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: got %0d active cycles want 0", done_cnt);
        end
        full_sweep("after_reset", GOLD, 0);
    endtask

    task automatic test_abort();
        int done_cnt;
        full_sweep("pre_abort", GOLD, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 16; c++) step();
        // cycle 16: first cycle of vector 5
        checks++;
        if (dut_in !== 3'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: got dut_in=%0d busy=%b want 5 1", dut_in, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || dut_in !== 3'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: got busy=%b dut_in=%0d done=%b want 0 0 0", busy, dut_in, done);
        end
        checks++;
        if (pass !== 1'b1 || fail_mask !== 8'h00) begin
            errors++;
            $display("FAIL abort_keep_result: got pass=%b mask=%h want 1 00", pass, fail_mask);
        end
        checks++;
        if (table_out !== 8'h11) begin
            errors++;
            $display("FAIL abort_partial_table: got %h want 11", table_out);
        end
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (done || busy) done_cnt++;
            step();
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        res_t r;
        int   dones;
        model_tbl = GOLD;
        exp_q1.push_back(predict(GOLD));
        exp_q1.push_back(predict(GOLD));
        dones = 0;
        start1 = 1'b1;
        step();
        for (int c = 1; c <= 40; c++) begin
            if (c <= 16 || (c >= 19 && c <= 34)) begin
                checks++;
                if (busy1 !== 1'b1 || dut_in1 !== 3'(((c <= 16) ? c - 1 : c - 19) / 2)) begin
                    errors++;
                    $display("FAIL b2b cyc %0d: got busy=%b dut_in=%0d want busy=1 dut_in=%0d",
                             c, busy1, dut_in1, ((c <= 16) ? c - 1 : c - 19) / 2);
                end
            end else begin
                checks++;
                if (busy1 !== 1'b0 || done1 !== (c == 17 || c == 35)) begin
                    errors++;
                    $display("FAIL b2b idle cyc %0d: got busy=%b done=%b want busy=0 done=%b",
                             c, busy1, done1, (c == 17 || c == 35));
                end
            end
            if (c == 19) begin
                checks++;
                if (table_out1 !== 8'h00) begin
                    errors++;
                    $display("FAIL b2b table_clear: got %h want 00", table_out1);
                end
            end
            if (done1) begin
                dones++;
                checks++;
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL b2b unexpected done at cyc %0d", c);
                end else begin
                    r = exp_q1.pop_front();
                    if (table_out1 !== r.tbl || pass1 !== r.pass || fail_mask1 !== r.mask) begin
                        errors++;
                        $display("FAIL b2b result: got tbl=%h pass=%b mask=%h want tbl=%h pass=%b mask=%h",
                                 table_out1, pass1, fail_mask1, r.tbl, r.pass, r.mask);
                    end
                end
            end
            if (c == 35) start1 = 1'b0;
            step();
        end
        checks++;
        if (dones != 2 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL b2b done count: got %0d want 2", dones);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_stuck_zero();
        test_start_while_busy();
        test_async_reset();
        test_abort();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
